// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the pocket-calculator processor.
//   - OPC_* opcode encodings (inst[15:10])
//   - instruction field bit positions
//   - mov_ctrl state encoding (3-bit)
//   - immediate sign-extension helper
package calc_pkg;

    localparam logic [5:0] OPC_NOP_ENC = 6'b000000;
    localparam logic [5:0] OPC_MOV_ENC = 6'b000101;

    // Instruction layout: [15:10] opcode, [9] I, [8] L, [7:5] dst, [4:0] imm5
    localparam int INST_OPC_HI  = 15;
    localparam int INST_OPC_LO  = 10;
    localparam int INST_I_BIT   = 9;
    localparam int INST_L_BIT   = 8;
    localparam int INST_DST_HI  = 7;
    localparam int INST_DST_LO  = 5;
    localparam int INST_IMM5_HI = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_FETCH  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_ABORT  = 3'd5
    } mov_state_e;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/mov_fetch_timer.sv
// mov_fetch_timer: cycle counter for the long-immediate fetch wait.
//   clk, rst_n : clock, async active-low reset
//   clr        : return count to 0 (held while not fetching)
//   en         : count this cycle (high while fetching)
//   expired    : current cycle is the LIMIT-th counted cycle
// The count holds the number of fetch cycles already elapsed, so it reads 0
// in the first fetch cycle and LIMIT-1 in the last one allowed.
module mov_fetch_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mov_ctrl.sv
// mov_ctrl: multi-cycle sequencer for the MOV datapath.
//   clk, rst_n              : clock, async active-low reset
//   inst_valid/inst_ready   : instruction handshake from the decoder (ready only in IDLE)
//   inst[15:0]              : opcode, I, L, dst, imm5
//   imm_req/imm_ack/imm_data: long-immediate fetch from the fetch unit
//   mov_en/mov_sel_imm/mov_imm, mov_data : mov datapath control and result
//   acc_we, rf_we, rf_waddr, wb_data     : write-back to accumulator / register file
//   done, err, busy         : retire/abort pulse, error qualifier, not-idle flag
// Outputs are decoded from the state register or come straight from flops,
// so nothing on the instruction side reaches an output combinationally.
module mov_ctrl
    import calc_pkg::*;
#(
    parameter logic [5:0] OPC_MOV       = OPC_MOV_ENC,
    parameter int         FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [15:0] inst,
    output logic        imm_req,
    input  logic        imm_ack,
    input  logic [15:0] imm_data,
    output logic        mov_en,
    output logic        mov_sel_imm,
    output logic [15:0] mov_imm,
    input  logic [15:0] mov_data,
    output logic        acc_we,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] wb_data,
    output logic        done,
    output logic        err,
    output logic        busy
);

    mov_state_e  state_q, state_d;
    logic [15:0] inst_q, inst_d;
    logic        sel_imm_q, sel_imm_d;
    logic [15:0] imm_q, imm_d;
    logic [15:0] result_q, result_d;
    logic        fetch_expired;

    logic [5:0] opc;
    logic       fld_i, fld_l;
    logic [2:0] dst;
    logic [4:0] imm5;

    assign opc   = inst_q[INST_OPC_HI:INST_OPC_LO];
    assign fld_i = inst_q[INST_I_BIT];
    assign fld_l = inst_q[INST_L_BIT];
    assign dst   = inst_q[INST_DST_HI:INST_DST_LO];
    assign imm5  = inst_q[INST_IMM5_HI:0];

    mov_fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != ST_FETCH),
        .en      (state_q == ST_FETCH),
        .expired (fetch_expired)
    );

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        sel_imm_d = sel_imm_q;
        imm_d     = imm_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid) begin
                    inst_d  = inst;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Operand source is fixed here and held through WB; a long
                // immediate later overwrites imm from the fetched word.
                sel_imm_d = fld_i;
                imm_d     = fld_i ? sext5(imm5) : 16'h0000;
                if (opc != OPC_MOV)
                    state_d = ST_ABORT;
                else if (fld_i && fld_l)
                    state_d = ST_FETCH;
                else
                    state_d = ST_EXEC;
            end
            ST_FETCH: begin
                // An ack in the expiry cycle still wins over the timeout.
                if (imm_ack) begin
                    imm_d   = imm_data;
                    state_d = ST_EXEC;
                end else if (fetch_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_EXEC: begin
                result_d = mov_data;
                state_d  = ST_WB;
            end
            ST_WB:    state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            inst_q    <= '0;
            sel_imm_q <= 1'b0;
            imm_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            sel_imm_q <= sel_imm_d;
            imm_q     <= imm_d;
            result_q  <= result_d;
        end
    end

    assign inst_ready  = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign imm_req     = (state_q == ST_FETCH);
    assign mov_en      = (state_q == ST_EXEC);
    assign mov_sel_imm = sel_imm_q;
    assign mov_imm     = imm_q;
    assign acc_we      = (state_q == ST_WB) && (dst == 3'd0);
    assign rf_we       = (state_q == ST_WB) && (dst != 3'd0);
    assign rf_waddr    = dst;
    assign wb_data     = result_q;
    assign done        = (state_q == ST_WB) || (state_q == ST_ABORT);
    assign err         = (state_q == ST_ABORT);

endmodule
